rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_if.sv | 43 ++++
 rtl/rf_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle for the register-file writeback arbiter: two requester channels,
// the RF write port and status. Defining RF_WB_BYPASS_EN adds the forwarding lookups.
interface rf_wb_arbiter_if;
   logic        WB0_VALID;
   logic        WB0_READY;
   logic [4:0]  WB0_ADR;
   logic [31:0] WB0_DATA;
   logic        WB1_VALID;
   logic        WB1_READY;
   logic [4:0]  WB1_ADR;
   logic [31:0] WB1_DATA;
   logic [4:0]  RF_WA;
   logic [31:0] RF_WD;
   logic        RF_EN;
   logic [31:0] PEND;
   logic        IDLE;
`ifdef RF_WB_BYPASS_EN
   logic [4:0]  BYP_ADR1;
   logic [4:0]  BYP_ADR2;
   logic        BYP_HIT1;
   logic        BYP_HIT2;
   logic [31:0] BYP_DATA1;
   logic [31:0] BYP_DATA2;
`endif

   modport master (
      output WB0_VALID, WB0_ADR, WB0_DATA, WB1_VALID, WB1_ADR, WB1_DATA,
      input  WB0_READY, WB1_READY, RF_WA, RF_WD, RF_EN, PEND, IDLE
`ifdef RF_WB_BYPASS_EN
      , output BYP_ADR1, BYP_ADR2
      , input  BYP_HIT1, BYP_HIT2, BYP_DATA1, BYP_DATA2
`endif
   );

   modport slave (
      input  WB0_VALID, WB0_ADR, WB0_DATA, WB1_VALID, WB1_ADR, WB1_DATA,
      output WB0_READY, WB1_READY, RF_WA, RF_WD, RF_EN, PEND, IDLE
`ifdef RF_WB_BYPASS_EN
      , input  BYP_ADR1, BYP_ADR2
      , output BYP_HIT1, BYP_HIT2, BYP_DATA1, BYP_DATA2
`endif
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter: per-requester FIFOs, round-robin
// grant, registered RF write port and pending-register scoreboard. Option: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   rf_wb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [4:0]  adr;
      logic [31:0] data;
   } entry_t;

   logic [1:0]       push_valid;
   entry_t [1:0]     push_entry;
   logic [1:0]       ready;
   logic [1:0]       not_empty;
   entry_t [1:0]     head;
   logic [1:0][31:0] fifo_pend;
   logic [1:0]       pop;

   logic        ready_en_q, ready_en_d;
   logic        last_q, last_d;
   logic        rf_en_q, rf_en_d;
   logic [4:0]  rf_wa_q, rf_wa_d;
   logic [31:0] rf_wd_q, rf_wd_d;
   logic        grant_any;
   logic        grant_sel;
   logic [31:0] out_pend;

   assign push_valid    = {bus.WB1_VALID, bus.WB0_VALID};
   assign push_entry[0] = {bus.WB0_ADR, bus.WB0_DATA};
   assign push_entry[1] = {bus.WB1_ADR, bus.WB1_DATA};

   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      entry_t           mem_q [DEPTH];
      entry_t           mem_d [DEPTH];
      logic             push;
      logic [PTR_W-1:0] off;
      logic [31:0]      pend;

      // READY looks only at occupancy, so a full FIFO refuses even while popping.
      assign ready[gi]     = ready_en_q && (cnt_q != CNT_W'(DEPTH));
      assign push          = push_valid[gi] && ready[gi];
      assign not_empty[gi] = (cnt_q != '0);
      assign head[gi]      = mem_q[rd_ptr_q];
      assign fifo_pend[gi] = pend;

      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         mem_d    = mem_q;
         if (push) begin
            mem_d[wr_ptr_q] = push_entry[gi];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop[gi]) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop[gi]);
      end

      always_comb begin
         pend = '0;
         off  = '0;
         for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, off} < cnt_q) && (mem_q[i].adr != 5'd0)) begin
               pend[mem_q[i].adr] = 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
         end
      end

      always_ff @(posedge clk) begin
         mem_q <= mem_d;
      end
   end

   // Eligibility comes from registered occupancy, so a fresh push never falls through.
   always_comb begin
      grant_any = |not_empty;
      if (&not_empty) begin
         grant_sel = ~last_q;
      end else begin
         grant_sel = not_empty[1];
      end
      pop = '0;
      if (grant_any) begin
         pop[grant_sel] = 1'b1;
      end
      last_d     = grant_any ? grant_sel : last_q;
      ready_en_d = 1'b1;
      rf_en_d    = 1'b0;
      rf_wa_d    = rf_wa_q;
      rf_wd_d    = rf_wd_q;
      if (grant_any) begin
         rf_en_d = (head[grant_sel].adr != 5'd0);
         rf_wa_d = head[grant_sel].adr;
         rf_wd_d = head[grant_sel].data;
      end
   end

   // last_q resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_q <= 1'b0;
         last_q     <= 1'b1;
         rf_en_q    <= 1'b0;
         rf_wa_q    <= 5'd0;
         rf_wd_q    <= 32'd0;
      end else begin
         ready_en_q <= ready_en_d;
         last_q     <= last_d;
         rf_en_q    <= rf_en_d;
         rf_wa_q    <= rf_wa_d;
         rf_wd_q    <= rf_wd_d;
      end
   end

   assign out_pend      = rf_en_q ? (32'd1 << rf_wa_q) : 32'd0;
   assign bus.WB0_READY = ready[0];
   assign bus.WB1_READY = ready[1];
   assign bus.RF_EN     = rf_en_q;
   assign bus.RF_WA     = rf_wa_q;
   assign bus.RF_WD     = rf_wd_q;
   assign bus.PEND      = (fifo_pend[0] | fifo_pend[1] | out_pend) & ~32'd1;
   assign bus.IDLE      = ~(|not_empty) & ~rf_en_q;

`ifdef RF_WB_BYPASS_EN
   logic byp_hit1;
   logic byp_hit2;
   assign byp_hit1      = rf_en_q && (bus.BYP_ADR1 != 5'd0) && (bus.BYP_ADR1 == rf_wa_q);
   assign byp_hit2      = rf_en_q && (bus.BYP_ADR2 != 5'd0) && (bus.BYP_ADR2 == rf_wa_q);
   assign bus.BYP_HIT1  = byp_hit1;
   assign bus.BYP_HIT2  = byp_hit2;
   assign bus.BYP_DATA1 = byp_hit1 ? rf_wd_q : 32'd0;
   assign bus.BYP_DATA2 = byp_hit2 ? rf_wd_q : 32'd0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, hand-written
// corner sequences, then a randomized phase checked against a queue scoreboard.
module tb_rf_wb_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rf_wb_arbiter_if bus ();
   rf_wb_arbiter #(.DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed { logic [4:0] adr; logic [31:0] data; } ent_t;
   typedef struct packed { logic en; logic [4:0] wa; logic [31:0] wd; } out_t;
   typedef struct {
      logic v0; logic [4:0] a0; logic [31:0] d0;
      logic v1; logic [4:0] a1; logic [31:0] d1;
      logic e_en; logic [4:0] e_wa; logic [31:0] e_wd;
      logic e_rdy0; logic e_rdy1;
   } vec_t;

   vec_t        tbl [10];
   int          n_cmp = 0;
   int          n_err = 0;
   ent_t        mq0[$];
   ent_t        mq1[$];
   out_t        exp_q[$];
   out_t        o;
   ent_t        e0, e1, h;
   logic        m_last, m_en, r0, r1, v0, v1, g, any, found;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
`ifdef RF_WB_BYPASS_EN
   logic        bh1, bh2;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] p;
      p = '0;
      foreach (mq0[i]) if (mq0[i].adr != 5'd0) p[mq0[i].adr] = 1'b1;
      foreach (mq1[i]) if (mq1[i].adr != 5'd0) p[mq1[i].adr] = 1'b1;
      if (m_en) p[m_wa] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic drive(input logic a_v0, input logic [4:0] a_a0, input logic [31:0] a_d0,
                        input logic a_v1, input logic [4:0] a_a1, input logic [31:0] a_d1);
      bus.WB0_VALID = a_v0; bus.WB0_ADR = a_a0; bus.WB0_DATA = a_d0;
      bus.WB1_VALID = a_v1; bus.WB1_ADR = a_a1; bus.WB1_DATA = a_d1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Contention + backpressure: WB1 held while WB0 saturates; grants alternate 0,1,0,1...
      tbl[0] = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h00, 1'b1, 1'b1};
      tbl[1] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 5'd1, 32'h11, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 5'd7, 32'h77, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 5'd0, 32'h00, 1'b1, 5'd8, 32'h88, 1'b1, 5'd5, 32'h55, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1, 5'd6, 32'h66, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b1, 5'd8, 32'h88, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b0, 5'd8, 32'h88, 1'b1, 1'b1};

      rst_n = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef RF_WB_BYPASS_EN
      bus.BYP_ADR1 = 5'd0;
      bus.BYP_ADR2 = 5'd0;
`endif
      #7;
      chk("rst_rdy0", 32'(bus.WB0_READY), 32'd0);
      chk("rst_rdy1", 32'(bus.WB1_READY), 32'd0);
      chk("rst_idle", 32'(bus.IDLE), 32'd1);
      chk("rst_pend", bus.PEND, 32'd0);
      chk("rst_en", 32'(bus.RF_EN), 32'd0);
      chk("rst_wa", 32'(bus.RF_WA), 32'd0);
      chk("rst_wd", bus.RF_WD, 32'd0);
      #5 rst_n = 1'b1;
      #1 chk("rel_rdy0_pre_edge", 32'(bus.WB0_READY), 32'd0);
      step();
      chk("rel_rdy0", 32'(bus.WB0_READY), 32'd1);
      chk("rel_rdy1", 32'(bus.WB1_READY), 32'd1);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
         step();
         chk($sformatf("tbl%0d_en", i), 32'(bus.RF_EN), 32'(tbl[i].e_en));
         chk($sformatf("tbl%0d_wa", i), 32'(bus.RF_WA), 32'(tbl[i].e_wa));
         chk($sformatf("tbl%0d_wd", i), bus.RF_WD, tbl[i].e_wd);
         chk($sformatf("tbl%0d_rdy0", i), 32'(bus.WB0_READY), 32'(tbl[i].e_rdy0));
         chk($sformatf("tbl%0d_rdy1", i), 32'(bus.WB1_READY), 32'(tbl[i].e_rdy1));
         $display("vector %0d: en=%0d wa=%0d wd=%h rdy=%0d%0d", i, bus.RF_EN, bus.RF_WA,
                  bus.RF_WD, bus.WB0_READY, bus.WB1_READY);
      end

      // Single write: latency and PEND lifetime.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("single_en_n", 32'(bus.RF_EN), 32'd0);
      chk("single_pend_n", bus.PEND, 32'h20);
      chk("single_idle_n", 32'(bus.IDLE), 32'd0);
      step();
      chk("single_en", 32'(bus.RF_EN), 32'd1);
      chk("single_wa", 32'(bus.RF_WA), 32'd5);
      chk("single_wd", bus.RF_WD, 32'hDEADBEEF);
      chk("single_pend", bus.PEND, 32'h20);
      step();
      chk("single_en_off", 32'(bus.RF_EN), 32'd0);
      chk("single_pend_off", bus.PEND, 32'd0);
      chk("single_idle", 32'(bus.IDLE), 32'd1);

      // Write to x0 is consumed but never enables the RF.
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("x0_pend_q", bus.PEND, 32'd0);
      chk("x0_idle_q", 32'(bus.IDLE), 32'd0);
      step();
      chk("x0_en", 32'(bus.RF_EN), 32'd0);
      chk("x0_wa", 32'(bus.RF_WA), 32'd0);
      chk("x0_wd", bus.RF_WD, 32'hFFFFFFFF);
      chk("x0_pend", bus.PEND, 32'd0);
      chk("x0_idle", 32'(bus.IDLE), 32'd1);

      // Asynchronous reset with queued work.
      drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         step();
         if (!bus.WB0_READY || !bus.WB1_READY) found = 1'b1;
      end
      chk("midrst_fill", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_en", 32'(bus.RF_EN), 32'd0);
      chk("midrst_rdy0", 32'(bus.WB0_READY), 32'd0);
      chk("midrst_rdy1", 32'(bus.WB1_READY), 32'd0);
      chk("midrst_idle", 32'(bus.IDLE), 32'd1);
      chk("midrst_pend", bus.PEND, 32'd0);
      chk("midrst_wa", 32'(bus.RF_WA), 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("postrst_rdy0", 32'(bus.WB0_READY), 32'd1);
      chk("postrst_rdy1", 32'(bus.WB1_READY), 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk("postrst_en", 32'(bus.RF_EN), 32'd0);
         chk("postrst_idle", 32'(bus.IDLE), 32'd1);
         step();
      end

      // Randomized traffic against the queue scoreboard; state is fresh from reset.
      m_last = 1'b1; m_en = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
      for (int c = 0; c < 400; c++) begin
         r0 = (mq0.size() < 2);
         r1 = (mq1.size() < 2);
         chk("rnd_rdy0", 32'(bus.WB0_READY), 32'(r0));
         chk("rnd_rdy1", 32'(bus.WB1_READY), 32'(r1));
         v0 = ($urandom_range(0, 3) != 0);
         v1 = ($urandom_range(0, 3) != 0);
         e0 = {5'($urandom_range(0, 7)), 32'($urandom)};
         e1 = {5'($urandom_range(0, 7)), 32'($urandom)};
         drive(v0, e0.adr, e0.data, v1, e1.adr, e1.data);
         any = (mq0.size() > 0) || (mq1.size() > 0);
         if ((mq0.size() > 0) && (mq1.size() > 0)) g = ~m_last;
         else g = (mq1.size() > 0);
         if (any) begin
            h = g ? mq1.pop_front() : mq0.pop_front();
            m_last = g;
            m_en = (h.adr != 5'd0);
            m_wa = h.adr;
            m_wd = h.data;
         end else begin
            m_en = 1'b0;
         end
         exp_q.push_back({m_en, m_wa, m_wd});
         if (v0 && r0) mq0.push_back(e0);
         if (v1 && r1) mq1.push_back(e1);
         step();
         o = exp_q.pop_front();
         chk("rnd_en", 32'(bus.RF_EN), 32'(o.en));
         chk("rnd_wa", 32'(bus.RF_WA), 32'(o.wa));
         chk("rnd_wd", bus.RF_WD, o.wd);
         chk("rnd_pend", bus.PEND, model_pend());
         chk("rnd_idle", 32'(bus.IDLE), 32'((mq0.size() == 0) && (mq1.size() == 0) && !m_en));
         if (bus.RF_EN) $display("rf write cycle %0d: reg %0d <= %h", c, bus.RF_WA, bus.RF_WD);
`ifdef RF_WB_BYPASS_EN
         bus.BYP_ADR1 = ($urandom_range(0, 1) == 0) ? m_wa : 5'($urandom_range(0, 31));
         bus.BYP_ADR2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
         #1;
         bh1 = m_en && (bus.BYP_ADR1 != 5'd0) && (bus.BYP_ADR1 == m_wa);
         bh2 = m_en && (bus.BYP_ADR2 != 5'd0) && (bus.BYP_ADR2 == m_wa);
         chk("byp_hit1", 32'(bus.BYP_HIT1), 32'(bh1));
         chk("byp_hit2", 32'(bus.BYP_HIT2), 32'(bh2));
         chk("byp_data1", bus.BYP_DATA1, bh1 ? m_wd : 32'd0);
         chk("byp_data2", bus.BYP_DATA2, bh2 ? m_wd : 32'd0);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
